// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//
// Shares one single-port memory slave (the BRAM controller) between two masters on the
// native valid/ready memory bus: port 0 is CPU instruction fetch, port 1 is CPU load/store.
//
// A grant is held for a whole transaction. After every completion the arbiter returns to
// IDLE for at least one cycle, so s_valid always drops between transactions and the slave
// FSM restarts from its idle state. A watchdog aborts a slave access that never completes.
//
// Parameters
//   ADDR_W   address width, all ports
//   DATA_W   data width; strobe width is DATA_W/8
//   RR_EN    1: round-robin on a tie; 0: port 0 always wins a tie
//   TIMEOUT  granted cycles before an access is aborted; 0 disables the watchdog
//
// Ports
//   clk, reset_n                   clock; synchronous active-low reset
//   m0_valid/addr/wdata/wstrb      port 0 request, held stable until m0_ready
//   m0_ready, m0_rdata             port 0 completion pulse and read data
//   m1_*                           port 1, same set as port 0
//   s_valid/addr/wdata/wstrb       request to the slave
//   s_ready, s_rdata               slave completion pulse and read data
//   bus_err                        sticky watchdog-abort flag, cleared only by reset

module mem_bus_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RR_EN   = 1,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset_n,

   input  logic                m0_valid,
   output logic                m0_ready,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wstrb,
   output logic [DATA_W-1:0]   m0_rdata,

   input  logic                m1_valid,
   output logic                m1_ready,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   output logic [DATA_W-1:0]   m1_rdata,

   output logic                s_valid,
   input  logic                s_ready,
   output logic [ADDR_W-1:0]   s_addr,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   input  logic [DATA_W-1:0]   s_rdata,

   output logic                bus_err
);

   localparam int unsigned STRB_W = DATA_W / 8;

   // The counter only has to reach TIMEOUT-1.
   localparam int unsigned WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StGrant0 = 2'd1,
      StGrant1 = 2'd2
   } state_e;

   state_e              state_q,   state_d;
   logic                last_q,    last_d;     // port that completed most recently
   logic [WDOG_W-1:0]   wdog_q,    wdog_d;
   logic                bus_err_q, bus_err_d;
   logic [ADDR_W-1:0]   addr_q,    addr_d;
   logic [DATA_W-1:0]   wdata_q,   wdata_d;
   logic [STRB_W-1:0]   wstrb_q,   wstrb_d;

   logic granted;
   logic wdog_expire;
   logic xfer_end;
   logic rr_pick1;
   logic pick0;
   logic pick1;

   // ---------------------------------------------------------------------------------
   // Arbitration and transaction-end decode
   // ---------------------------------------------------------------------------------
   always_comb begin
      granted     = (state_q != StIdle);
      // Abort only when the slave is not completing in this very cycle.
      wdog_expire = (TIMEOUT != 0) && granted && (wdog_q == WDOG_LAST) && !s_ready;
      xfer_end    = granted && (s_ready || wdog_expire);

      // On a tie round-robin hands the grant to the port that did not finish last.
      rr_pick1    = (RR_EN != 0) && !last_q;
      pick1       = m1_valid && (!m0_valid || rr_pick1);
      pick0       = m0_valid && !pick1;
   end

   // ---------------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      wdog_d    = wdog_q;
      bus_err_d = bus_err_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;

      unique case (state_q)
         StIdle: begin
            wdog_d = '0;
            if (pick0) begin
               state_d = StGrant0;
               addr_d  = m0_addr;
               wdata_d = m0_wdata;
               wstrb_d = m0_wstrb;
            end else if (pick1) begin
               state_d = StGrant1;
               addr_d  = m1_addr;
               wdata_d = m1_wdata;
               wstrb_d = m1_wstrb;
            end
         end

         StGrant0, StGrant1: begin
            if (xfer_end) begin
               state_d = StIdle;
               wdog_d  = '0;
               // Only a real slave completion moves the round-robin pointer.
               if (s_ready) begin
                  last_d = (state_q == StGrant1);
               end
               if (wdog_expire) begin
                  bus_err_d = 1'b1;
               end
            end else if (TIMEOUT != 0) begin
               wdog_d = wdog_q + 1'b1;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         last_q    <= 1'b1;
         wdog_q    <= '0;
         bus_err_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         wdog_q    <= wdog_d;
         bus_err_q <= bus_err_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
      end
   end

   // ---------------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------------
   always_comb begin
      s_valid  = 1'b0;
      s_addr   = addr_q;
      s_wdata  = wdata_q;
      s_wstrb  = '0;
      m0_ready = 1'b0;
      m1_ready = 1'b0;
      m0_rdata = s_rdata;
      m1_rdata = s_rdata;

      unique case (state_q)
         StGrant0: begin
            s_valid  = 1'b1;
            s_wstrb  = wstrb_q;
            // Gated by reset so a transaction killed by reset never completes.
            m0_ready = xfer_end && reset_n;
            if (wdog_expire) begin
               m0_rdata = '0;
            end
         end

         StGrant1: begin
            s_valid  = 1'b1;
            s_wstrb  = wstrb_q;
            m1_ready = xfer_end && reset_n;
            if (wdog_expire) begin
               m1_rdata = '0;
            end
         end

         default: begin
         end
      endcase
   end

   assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

   localparam int unsigned TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        reset_n;

   logic        m0_valid, m0_ready, m1_valid, m1_ready;
   logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        s_valid, s_ready, bus_err;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;

   // Master request registers, index = port
   logic        mv [2];
   logic [31:0] ma [2];
   logic [31:0] mw [2];
   logic [3:0]  ms [2];

   assign m0_valid = mv[0];
   assign m0_addr  = ma[0];
   assign m0_wdata = mw[0];
   assign m0_wstrb = ms[0];
   assign m1_valid = mv[1];
   assign m1_addr  = ma[1];
   assign m1_wdata = mw[1];
   assign m1_wstrb = ms[1];

   mem_bus_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .RR_EN   (1),
      .TIMEOUT (TIMEOUT)
   ) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .m0_valid (m0_valid),
      .m0_ready (m0_ready),
      .m0_addr  (m0_addr),
      .m0_wdata (m0_wdata),
      .m0_wstrb (m0_wstrb),
      .m0_rdata (m0_rdata),
      .m1_valid (m1_valid),
      .m1_ready (m1_ready),
      .m1_addr  (m1_addr),
      .m1_wdata (m1_wdata),
      .m1_wstrb (m1_wstrb),
      .m1_rdata (m1_rdata),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_wstrb  (s_wstrb),
      .s_rdata  (s_rdata),
      .bus_err  (bus_err)
   );

   // Fixed-priority instance, watchdog disabled
   logic        fp_m0_valid = 1'b0, fp_m1_valid = 1'b0;
   logic        fp_m0_ready, fp_m1_ready, fp_s_valid, fp_s_ready, fp_bus_err;
   logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
   logic [3:0]  fp_s_wstrb;
   logic [31:0] fp_m0_addr  = 32'h40;
   logic [31:0] fp_m1_addr  = 32'h80;
   logic [31:0] fp_zero     = 32'h0;
   logic [3:0]  fp_zstrb    = 4'h0;
   logic [31:0] fp_s_rdata  = 32'h1234_5678;
   int          fp_scnt;

   mem_bus_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .RR_EN   (0),
      .TIMEOUT (0)
   ) u_dut_fp (
      .clk      (clk),
      .reset_n  (reset_n),
      .m0_valid (fp_m0_valid),
      .m0_ready (fp_m0_ready),
      .m0_addr  (fp_m0_addr),
      .m0_wdata (fp_zero),
      .m0_wstrb (fp_zstrb),
      .m0_rdata (fp_m0_rdata),
      .m1_valid (fp_m1_valid),
      .m1_ready (fp_m1_ready),
      .m1_addr  (fp_m1_addr),
      .m1_wdata (fp_zero),
      .m1_wstrb (fp_zstrb),
      .m1_rdata (fp_m1_rdata),
      .s_valid  (fp_s_valid),
      .s_ready  (fp_s_ready),
      .s_addr   (fp_s_addr),
      .s_wdata  (fp_s_wdata),
      .s_wstrb  (fp_s_wstrb),
      .s_rdata  (fp_s_rdata),
      .bus_err  (fp_bus_err)
   );

   // Simple slave for the fixed-priority instance: completes on the third valid cycle
   assign fp_s_ready = fp_s_valid && (fp_scnt == 2);
   always @(posedge clk) begin
      if (!reset_n) fp_scnt <= 0;
      else          fp_scnt <= (fp_s_valid && !fp_s_ready) ? fp_scnt + 1 : 0;
   end

   always #5 clk = ~clk;

   // Slave memory (driven by the DUT's bus) and independent reference memory
   logic [31:0] slv_mem [256];
   logic [31:0] ref_mem [256];

   assign s_rdata = slv_mem[s_addr[9:2]];

   always @(posedge clk) begin
      if (reset_n && s_valid && s_ready) begin
         for (int b = 0; b < 4; b++) begin
            if (s_wstrb[b]) slv_mem[s_addr[9:2]][b*8 +: 8] <= s_wdata[b*8 +: 8];
         end
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: transaction-level view of the bus
   int          owner;      // -1 none, else granted port
   int          cnt;        // cycles spent in the current grant
   int          lat;        // slave latency chosen for the current grant
   int          last;       // port that completed most recently
   logic        err;
   logic        have_addr;
   logic [31:0] last_addr;
   logic        done_flag [2];

   // Stimulus knobs
   int   p_new;
   int   p_b2b;
   logic hang;
   logic stray_en;

   task automatic new_req(input int n);
      mv[n] = 1'b1;
      ma[n] = {22'd0, 4'($urandom_range(0, 15)), 2'b00} << 4;
      mw[n] = $urandom;
      ms[n] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
   endtask

   task automatic issue(input int n, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      mv[n] = 1'b1;
      ma[n] = a;
      mw[n] = d;
      ms[n] = s;
      done_flag[n] = 1'b0;
   endtask

   task automatic model_reset();
      owner        = -1;
      cnt          = 0;
      last         = 1;
      err          = 1'b0;
      have_addr    = 1'b0;
      done_flag[0] = 1'b0;
      done_flag[1] = 1'b0;
   endtask

   // One bus cycle: update masters and slave at negedge, check, then cross the posedge.
   task automatic step();
      int          n;
      int          win;
      logic        fin;
      logic        tout;
      logic [7:0]  idx;
      logic [31:0] rd;
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
         if (done_flag[p]) begin
            done_flag[p] = 1'b0;
            if ($urandom_range(0, 99) < p_b2b) new_req(p);
            else                               mv[p] = 1'b0;
         end else if (!mv[p] && ($urandom_range(0, 99) < p_new)) begin
            new_req(p);
         end
      end
      if (owner >= 0) s_ready = !hang && (cnt == lat);
      else            s_ready = stray_en && ($urandom_range(0, 7) == 0);
      #1;
      check("bus_err", bus_err, err);
      if (owner < 0) begin
         check("s_valid idle", s_valid, 0);
         check("m0_ready idle", m0_ready, 0);
         check("m1_ready idle", m1_ready, 0);
         check("s_wstrb idle", s_wstrb, 0);
         if (have_addr) check("s_addr hold", s_addr, last_addr);
         if (mv[0] && mv[1]) win = (last == 0) ? 1 : 0;
         else if (mv[0])     win = 0;
         else if (mv[1])     win = 1;
         else                win = -1;
         if (win >= 0) begin
            owner     = win;
            cnt       = 0;
            lat       = $urandom_range(1, 6);
            last_addr = ma[win];
            have_addr = 1'b1;
         end
      end else begin
         n    = owner;
         idx  = ma[n][9:2];
         tout = !s_ready && (cnt == TIMEOUT - 1);
         fin  = s_ready || tout;
         rd   = (n == 0) ? m0_rdata : m1_rdata;
         check("s_valid grant", s_valid, 1);
         check("s_addr", s_addr, ma[n]);
         check("s_wdata", s_wdata, mw[n]);
         check("s_wstrb", s_wstrb, {28'd0, ms[n]});
         check(n == 0 ? "m0_ready" : "m1_ready", n == 0 ? m0_ready : m1_ready, fin);
         check(n == 0 ? "m1_ready other" : "m0_ready other", n == 0 ? m1_ready : m0_ready, 0);
         if (s_ready) begin
            check("rdata", rd, ref_mem[idx]);
            for (int b = 0; b < 4; b++) begin
               if (ms[n][b]) ref_mem[idx][b*8 +: 8] = mw[n][b*8 +: 8];
            end
            last = n;
         end
         if (tout) begin
            check("rdata abort", rd, 0);
            err = 1'b1;
         end
         if (fin) begin
            owner        = -1;
            done_flag[n] = 1'b1;
         end else begin
            cnt++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_done(input int n, input string tag);
      int k = 0;
      while (!done_flag[n] && k < 50) begin
         step();
         k++;
      end
      if (!done_flag[n]) check(tag, 0, 1);
   endtask

   initial begin
      int          fp_ready_cnt;
      logic [31:0] v;
      for (int i = 0; i < 256; i++) begin
         v          = $urandom;
         slv_mem[i] = v;
         ref_mem[i] = v;
      end
      slv_mem[0] = 32'h0000_1537;
      ref_mem[0] = 32'h0000_1537;
      for (int p = 0; p < 2; p++) begin
         mv[p] = 1'b0;
         ma[p] = '0;
         mw[p] = '0;
         ms[p] = '0;
      end
      s_ready  = 1'b0;
      reset_n  = 1'b0;
      p_new    = 0;
      p_b2b    = 0;
      hang     = 1'b0;
      stray_en = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Reset state, then directed read of the preloaded word
      step();
      issue(0, 32'h0, 32'h0, 4'h0);
      run_until_done(0, "m0 read bound");

      // Write then read on port 1
      step();
      issue(1, 32'h200, 32'hCAFE_F00D, 4'hF);
      run_until_done(1, "m1 write bound");
      issue(1, 32'h200, 32'h0, 4'h0);
      run_until_done(1, "m1 read bound");

      // Port 1 arrives while port 0 is mid-transaction
      step();
      issue(0, 32'h10, 32'h0, 4'h0);
      step();
      step();
      issue(1, 32'h24, 32'h0, 4'h0);
      run_until_done(0, "m0 busy bound");
      run_until_done(1, "m1 queued bound");

      // Randomized traffic with stray slave readies
      p_new    = 30;
      p_b2b    = 50;
      stray_en = 1'b1;
      repeat (600) step();

      // Continuous contention
      p_new = 100;
      p_b2b = 100;
      repeat (120) step();

      // Hung slave
      p_new = 40;
      p_b2b = 50;
      hang  = 1'b1;
      repeat (60) step();
      hang = 1'b0;
      repeat (60) step();

      // Reset while port 1 is granted
      begin
         int k = 0;
         while (owner != 1 && k < 300) begin
            step();
            k++;
         end
         if (owner != 1) check("reach GRANT1 bound", 0, 1);
      end
      reset_n = 1'b0;
      @(negedge clk);
      s_ready = 1'b0;
      #1;
      check("m1_ready in reset", m1_ready, 0);
      check("m0_ready in reset", m0_ready, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
      mv[1] = 1'b1;
      if (!mv[0]) new_req(0);
      step();
      if (owner != 0) check("port0 first after reset", owner, 0);
      repeat (200) step();

      // Fixed priority: port 0 granted every time, port 1 starves
      p_new = 0;
      p_b2b = 0;
      fp_ready_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0) begin
            fp_m0_valid = 1'b1;
            fp_m1_valid = 1'b1;
         end
         #1;
         check("fp m1_ready", fp_m1_ready, 0);
         if (fp_s_valid) check("fp s_addr", fp_s_addr, 32'h40);
         if (fp_m0_ready) begin
            fp_ready_cnt++;
            check("fp m0_rdata", fp_m0_rdata, 32'h1234_5678);
         end
      end
      check("fp m0 grant count", fp_ready_cnt, 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
